screen_state_fsm: RTL and testbench

SCREEN_STATE_FSM -- requirements
Module: screen_state_fsm

---
 rtl/screen_state_fsm.sv | 258 +++++++++++++++++++++++++
 tb/tb_screen_state_fsm.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/screen_state_fsm.sv
// ----------------------------------------------------------------------------
// screen_state_fsm
//
// Top-level game-flow controller. It sequences the welcome, play, freeze and
// game-over screens and keeps the lives and level counters.
//
// Optional feature macro: SCREEN_STATE_FSM_PAUSE_EN
//   When defined, adds a PAUSE state that is toggled from PLAY by pauseKey.
//   When undefined, the PAUSE state is absent and pauseKey is unused.
//
// Parameters
//   INIT_LIVES      lives loaded at the start of a new game (1..3)
//   MAX_LEVEL       number of the final level (1..7)
//   FREEZE_FRAMES   frames gameplay stays frozen after a hit or level-up (1..255)
//   GAMEOVER_FRAMES minimum frames the game-over screen is held (1..255)
//
// Ports
//   clk           system clock
//   reset         synchronous active-high reset
//   startOfFrame  one-cycle pulse per video frame
//   startKey      level-sensitive start/confirm key
//   playerHit     one-cycle pulse on player/ball collision
//   levelCleared  one-cycle pulse when all balls are destroyed
//   pauseKey      level-sensitive pause key (PAUSE_EN builds only)
//   selector      screen select: 0 welcome, 1 play, 2 game over
//   lives         remaining lives
//   level         current level number
//   freeze        gameplay objects must hold position
//   newGame       one-cycle pulse re-initialising game objects
//   gameWon       set on the game-over screen when the final level was cleared
// ----------------------------------------------------------------------------
module screen_state_fsm #(
  parameter int INIT_LIVES      = 3,
  parameter int MAX_LEVEL       = 4,
  parameter int FREEZE_FRAMES   = 60,
  parameter int GAMEOVER_FRAMES = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       startKey,
  input  logic       playerHit,
  input  logic       levelCleared,
  input  logic       pauseKey,
  output logic [1:0] selector,
  output logic [1:0] lives,
  output logic [2:0] level,
  output logic       freeze,
  output logic       newGame,
  output logic       gameWon
);

`ifdef SCREEN_STATE_FSM_PAUSE_EN
  typedef enum logic [2:0] {
    ST_WELCOME  = 3'd0,
    ST_PLAY     = 3'd1,
    ST_FREEZE   = 3'd2,
    ST_GAMEOVER = 3'd3,
    ST_PAUSE    = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_WELCOME  = 3'd0,
    ST_PLAY     = 3'd1,
    ST_FREEZE   = 3'd2,
    ST_GAMEOVER = 3'd3
  } state_t;
`endif

  state_t      r_state;
  state_t      w_state_nxt;

  // Key sampling: r_*_q is the registered key, r_*_d its one-cycle-delayed
  // copy. The edge is therefore acted on one cycle after the key is sampled.
  logic        r_start_q;
  logic        r_start_d;
  logic        w_start_edge;

  logic [7:0]  r_frame_cnt;
  logic [7:0]  w_frame_nxt;
  logic [1:0]  r_lives;
  logic [1:0]  w_lives_nxt;
  logic [2:0]  r_level;
  logic [2:0]  w_level_nxt;
  logic        r_game_won;
  logic        w_game_won_nxt;
  logic        r_new_game;
  logic        w_new_game_nxt;
  logic [1:0]  r_selector;
  logic [1:0]  w_selector_nxt;
  logic        r_freeze;
  logic        w_freeze_nxt;

  logic        w_freeze_done;
  logic        w_go_sat;
  logic        w_last_life;
  logic        w_last_level;

`ifdef SCREEN_STATE_FSM_PAUSE_EN
  logic        r_pause_q;
  logic        r_pause_d;
  logic        w_pause_edge;

  assign w_pause_edge = r_pause_q & ~r_pause_d;
`else
  logic        w_unused_pause;

  assign w_unused_pause = pauseKey;
`endif

  assign w_start_edge = r_start_q & ~r_start_d;

  // The FREEZE_FRAMES-th pulse ends the freeze on the cycle it is counted.
  // Widened compare so the counter itself never has to reach a wrapping value.
  assign w_freeze_done = startOfFrame &&
                         (({1'b0, r_frame_cnt} + 9'd1) == 9'(FREEZE_FRAMES));
  assign w_go_sat      = (r_frame_cnt >= 8'(GAMEOVER_FRAMES));
  assign w_last_life   = (r_lives <= 2'd1);
  assign w_last_level  = (r_level >= 3'(MAX_LEVEL));

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_WELCOME;
      r_start_q   <= 1'b1;
      r_start_d   <= 1'b1;
      r_frame_cnt <= 8'd0;
      r_lives     <= 2'd0;
      r_level     <= 3'd0;
      r_game_won  <= 1'b0;
      r_new_game  <= 1'b0;
      r_selector  <= 2'd0;
      r_freeze    <= 1'b0;
`ifdef SCREEN_STATE_FSM_PAUSE_EN
      r_pause_q   <= 1'b1;
      r_pause_d   <= 1'b1;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_start_q   <= startKey;
      r_start_d   <= r_start_q;
      r_frame_cnt <= w_frame_nxt;
      r_lives     <= w_lives_nxt;
      r_level     <= w_level_nxt;
      r_game_won  <= w_game_won_nxt;
      r_new_game  <= w_new_game_nxt;
      r_selector  <= w_selector_nxt;
      r_freeze    <= w_freeze_nxt;
`ifdef SCREEN_STATE_FSM_PAUSE_EN
      r_pause_q   <= pauseKey;
      r_pause_d   <= r_pause_q;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_WELCOME: begin
        if (w_start_edge) w_state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        // playerHit wins over levelCleared when both arrive together.
        if (playerHit) begin
          w_state_nxt = w_last_life ? ST_GAMEOVER : ST_FREEZE;
        end else if (levelCleared) begin
          w_state_nxt = w_last_level ? ST_GAMEOVER : ST_FREEZE;
        end
`ifdef SCREEN_STATE_FSM_PAUSE_EN
        else if (w_pause_edge) begin
          w_state_nxt = ST_PAUSE;
        end
`endif
      end
      ST_FREEZE: begin
        if (w_freeze_done) w_state_nxt = ST_PLAY;
      end
      ST_GAMEOVER: begin
        if (w_go_sat && w_start_edge) w_state_nxt = ST_WELCOME;
      end
`ifdef SCREEN_STATE_FSM_PAUSE_EN
      ST_PAUSE: begin
        if (w_pause_edge) w_state_nxt = ST_PLAY;
      end
`endif
      default: w_state_nxt = ST_WELCOME;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    w_lives_nxt    = r_lives;
    w_level_nxt    = r_level;
    w_game_won_nxt = r_game_won;
    w_new_game_nxt = 1'b0;

    case (r_state)
      ST_WELCOME: begin
        if (w_start_edge) begin
          w_lives_nxt    = 2'(INIT_LIVES);
          w_level_nxt    = 3'd1;
          w_game_won_nxt = 1'b0;
          w_new_game_nxt = 1'b1;
        end
      end
      ST_PLAY: begin
        if (playerHit) begin
          w_lives_nxt = w_last_life ? 2'd0 : (r_lives - 2'd1);
        end else if (levelCleared) begin
          if (w_last_level) w_game_won_nxt = 1'b1;
          else              w_level_nxt    = r_level + 3'd1;
        end
      end
      ST_GAMEOVER: begin
        if (w_go_sat && w_start_edge) w_game_won_nxt = 1'b0;
      end
      default: ;
    endcase

    // Frame counter restarts on every state entry; in GAMEOVER it saturates.
    if (w_state_nxt != r_state) begin
      w_frame_nxt = 8'd0;
    end else if (startOfFrame &&
                 ((r_state == ST_FREEZE) ||
                  ((r_state == ST_GAMEOVER) && !w_go_sat))) begin
      w_frame_nxt = r_frame_cnt + 8'd1;
    end else begin
      w_frame_nxt = r_frame_cnt;
    end

    case (w_state_nxt)
      ST_WELCOME:  w_selector_nxt = 2'd0;
      ST_GAMEOVER: w_selector_nxt = 2'd2;
      default:     w_selector_nxt = 2'd1;
    endcase

`ifdef SCREEN_STATE_FSM_PAUSE_EN
    w_freeze_nxt = (w_state_nxt == ST_FREEZE) || (w_state_nxt == ST_PAUSE);
`else
    w_freeze_nxt = (w_state_nxt == ST_FREEZE);
`endif
  end

  assign selector = r_selector;
  assign lives    = r_lives;
  assign level    = r_level;
  assign freeze   = r_freeze;
  assign newGame  = r_new_game;
  assign gameWon  = r_game_won;

endmodule

// File: tb/tb_screen_state_fsm.sv
// ----------------------------------------------------------------------------
// tb_screen_state_fsm
//
// Directed bench for screen_state_fsm (default parameters). A cycle-level
// game-flow model tracks which screen should be showing and the lives/level
// scores; every cycle the DUT outputs are compared with it. Hand-computed
// literal expectations at key points pin the model itself.
// ----------------------------------------------------------------------------
module tb_screen_state_fsm;

  localparam int INIT_LIVES      = 3;
  localparam int MAX_LEVEL       = 4;
  localparam int FREEZE_FRAMES   = 60;
  localparam int GAMEOVER_FRAMES = 180;

  logic       clk;
  logic       reset;
  logic       startOfFrame;
  logic       startKey;
  logic       playerHit;
  logic       levelCleared;
  logic       pauseKey;
  logic [1:0] selector;
  logic [1:0] lives;
  logic [2:0] level;
  logic       freeze;
  logic       newGame;
  logic       gameWon;

  screen_state_fsm #(
    .INIT_LIVES     (INIT_LIVES),
    .MAX_LEVEL      (MAX_LEVEL),
    .FREEZE_FRAMES  (FREEZE_FRAMES),
    .GAMEOVER_FRAMES(GAMEOVER_FRAMES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .startOfFrame(startOfFrame),
    .startKey    (startKey),
    .playerHit   (playerHit),
    .levelCleared(levelCleared),
    .pauseKey    (pauseKey),
    .selector    (selector),
    .lives       (lives),
    .level       (level),
    .freeze      (freeze),
    .newGame     (newGame),
    .gameWon     (gameWon)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ng_cnt   = 0;

`ifdef SCREEN_STATE_FSM_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Game-flow model. Screens: "welcome", "playing", "frozen", "over",
  // "paused". Key history holds the values seen at the last two clocks; an
  // edge is the key seen high one clock ago after being low the clock before.
  // --------------------------------------------------------------------------
  string m_screen;
  int    m_lives, m_level, m_frames;
  int    m_won, m_ng;
  bit    sk_hist [2];
  bit    pk_hist [2];
  bit    m_se, m_pe;

  task automatic model_step();
    if (reset) begin
      m_screen = "welcome";
      m_lives = 0; m_level = 0; m_frames = 0; m_won = 0; m_ng = 0;
      sk_hist[0] = 1'b1; sk_hist[1] = 1'b1;
      pk_hist[0] = 1'b1; pk_hist[1] = 1'b1;
      return;
    end
    m_se = sk_hist[0] && !sk_hist[1];
    m_pe = pk_hist[0] && !pk_hist[1] && PAUSE_EN;
    m_ng = 0;
    if (m_screen == "welcome") begin
      if (m_se) begin
        m_screen = "playing";
        m_lives = INIT_LIVES; m_level = 1; m_won = 0; m_ng = 1; m_frames = 0;
      end
    end else if (m_screen == "playing") begin
      if (playerHit) begin
        if (m_lives > 1) begin m_lives--; m_screen = "frozen"; end
        else begin m_lives = 0; m_screen = "over"; end
        m_frames = 0;
      end else if (levelCleared) begin
        if (m_level < MAX_LEVEL) begin m_level++; m_screen = "frozen"; end
        else begin m_won = 1; m_screen = "over"; end
        m_frames = 0;
      end else if (m_pe) begin
        m_screen = "paused";
      end
    end else if (m_screen == "frozen") begin
      if (startOfFrame) begin
        m_frames++;
        if (m_frames == FREEZE_FRAMES) begin m_screen = "playing"; m_frames = 0; end
      end
    end else if (m_screen == "over") begin
      if (m_se && m_frames >= GAMEOVER_FRAMES) begin
        m_screen = "welcome"; m_won = 0; m_frames = 0;
      end else if (startOfFrame && m_frames < GAMEOVER_FRAMES) begin
        m_frames++;
      end
    end else if (m_screen == "paused") begin
      if (m_pe) m_screen = "playing";
    end
    sk_hist[1] = sk_hist[0]; sk_hist[0] = startKey;
    pk_hist[1] = pk_hist[0]; pk_hist[0] = pauseKey;
  endtask

  function automatic logic [7:0] exp_sel();
    if (m_screen == "welcome") return 8'd0;
    if (m_screen == "over")    return 8'd2;
    return 8'd1;
  endfunction

  function automatic logic [7:0] exp_frz();
    return (m_screen == "frozen" || m_screen == "paused") ? 8'd1 : 8'd0;
  endfunction

  always @(posedge clk) begin
    model_step();
    #1;
    chk("model_selector", 8'(selector), exp_sel());
    chk("model_lives",    8'(lives),    8'(m_lives));
    chk("model_level",    8'(level),    8'(m_level));
    chk("model_freeze",   8'(freeze),   exp_frz());
    chk("model_newGame",  8'(newGame),  8'(m_ng));
    chk("model_gameWon",  8'(gameWon),  8'(m_won));
    if (newGame === 1'b1) ng_cnt++;
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers: inputs change on the falling edge
  // --------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_start();
    startKey = 1'b1; tick(1);
    startKey = 1'b0; tick(1);
  endtask

  task automatic press_pause();
    pauseKey = 1'b1; tick(1);
    pauseKey = 1'b0; tick(1);
  endtask

  task automatic pulse(input bit hit, input bit clr);
    playerHit = hit; levelCleared = clr; tick(1);
    playerHit = 1'b0; levelCleared = 1'b0; tick(1);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      startOfFrame = 1'b1; tick(1);
      startOfFrame = 1'b0; tick(2);
    end
  endtask

  int ng_before;

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; startKey = 1'b0;
    playerHit = 1'b0; levelCleared = 1'b0; pauseKey = 1'b0;
    tick(3);
    chk("rst_selector", 8'(selector), 8'd0);
    chk("rst_lives",    8'(lives),    8'd0);
    chk("rst_level",    8'(level),    8'd0);
    chk("rst_freeze",   8'(freeze),   8'd0);
    chk("rst_newGame",  8'(newGame),  8'd0);
    chk("rst_gameWon",  8'(gameWon),  8'd0);
    reset = 1'b0; tick(2);

    // WELCOME ignores hits, clears and pause
    pulse(1'b1, 1'b1);
    press_pause();
    chk("welcome_ignore_sel",   8'(selector), 8'd0);
    chk("welcome_ignore_lives", 8'(lives),    8'd0);
    chk("welcome_ignore_frz",   8'(freeze),   8'd0);

    // New game
    ng_before = ng_cnt;
    press_start();
    chk("start_newGame_now", 8'(newGame), 8'd1);
    tick(3);
    chk("start_ng_pulses", 8'(ng_cnt - ng_before), 8'd1);
    chk("start_sel",   8'(selector), 8'd1);
    chk("start_lives", 8'(lives),    8'd3);
    chk("start_level", 8'(level),    8'd1);

`ifdef SCREEN_STATE_FSM_PAUSE_EN
    press_pause();
    chk("pause_frz", 8'(freeze), 8'd1);
    pulse(1'b1, 1'b0);
    chk("pause_hit_lives", 8'(lives), 8'd3);
    press_pause();
    chk("unpause_frz", 8'(freeze),   8'd0);
    chk("unpause_sel", 8'(selector), 8'd1);
`else
    press_pause();
    chk("nopause_frz", 8'(freeze), 8'd0);
`endif

    // Hit -> freeze for 60 frames; hits during freeze ignored
    pulse(1'b1, 1'b0);
    chk("hit1_lives", 8'(lives),  8'd2);
    chk("hit1_frz",   8'(freeze), 8'd1);
    frames(30);
    pulse(1'b1, 1'b1);
    chk("frz_hit_ignored", 8'(lives), 8'd2);
    frames(29);
    chk("frz_59_still", 8'(freeze), 8'd1);
    frames(1);
    chk("frz_60_done", 8'(freeze),   8'd0);
    chk("frz_60_sel",  8'(selector), 8'd1);

    // Down to the last life, then hit + clear together
    pulse(1'b1, 1'b0);
    chk("hit2_lives", 8'(lives), 8'd1);
    frames(60);
    pulse(1'b1, 1'b1);
    chk("last_lives", 8'(lives),    8'd0);
    chk("last_sel",   8'(selector), 8'd2);
    chk("last_won",   8'(gameWon),  8'd0);
    chk("last_level", 8'(level),    8'd1);
    frames(10);
    press_start();
    chk("go_early_start", 8'(selector), 8'd2);
    frames(200);
    press_start();
    chk("go_exit_sel", 8'(selector), 8'd0);

    // Win path through all levels
    press_start();
    chk("g2_lives", 8'(lives), 8'd3);
    for (int lv = 2; lv <= MAX_LEVEL; lv++) begin
      pulse(1'b0, 1'b1);
      chk("lvl_up", 8'(level), 8'(lv));
      frames(60);
    end
    pulse(1'b0, 1'b1);
    chk("win_sel",   8'(selector), 8'd2);
    chk("win_won",   8'(gameWon),  8'd1);
    chk("win_level", 8'(level),    8'd4);
    frames(100);
    press_start();
    chk("win_start100_sel", 8'(selector), 8'd2);
    frames(79);
    press_start();
    chk("win_start179_sel", 8'(selector), 8'd2);
    frames(1);
    press_start();
    chk("win_exit_sel", 8'(selector), 8'd0);
    chk("win_exit_won", 8'(gameWon),  8'd0);

    // Key held through reset gives no edge
    ng_before = ng_cnt;
    startKey = 1'b1; reset = 1'b1; tick(3);
    reset = 1'b0; tick(10);
    chk("held_sel", 8'(selector), 8'd0);
    chk("held_ng",  8'(ng_cnt - ng_before), 8'd0);
    startKey = 1'b0; tick(2);
    press_start();
    chk("held_then_press_sel", 8'(selector), 8'd1);
    chk("held_then_press_ng",  8'(ng_cnt - ng_before), 8'd1);

    // Reset in the middle of a freeze
    pulse(1'b1, 1'b0);
    frames(20);
    reset = 1'b1; tick(1);
    chk("midrst_sel",   8'(selector), 8'd0);
    chk("midrst_lives", 8'(lives),    8'd0);
    chk("midrst_level", 8'(level),    8'd0);
    chk("midrst_frz",   8'(freeze),   8'd0);
    reset = 1'b0; tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
